dvp_camera_source: RTL and testbench
====================================

// Module: dvp_camera_source
// PURPOSE
//  OV7670-style DVP transmitter. Generates p_clock, vsync, href and RGB565 byte
//  data with a built-in test pattern. Feeds camera_read in simulation and
//  board loopback so the capture path is tested without a sensor. Single clk domain.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line
//  H_TOTAL      784  pixel times per line (active + blank)
//  VSYNC_LINES  3    lines with vsync high
//  V_BACK       17   blank lines after vsync, before the first active line
//  V_ACTIVE     480  active lines
//  V_FRONT      10   blank lines after the last active line
// PORTS
//  clk          in   1   system clock; byte rate = clk/2
//  resetn       in   1   asynchronous, active-low reset
//  enable       in   1   run frames while high
//  mode         in   2   pattern select, latched at frame start
//  solid_rgb    in   16  RGB565 colour used by mode 2
//  p_clock      out  1   pixel byte clock (clk/2), free-running out of reset
//  vsync        out  1   frame sync, active high
//  href         out  1   line valid, active high
//  p_data       out  8   byte data, RGB565 high byte first
//  frame_start  out  1   1-clk pulse when vsync rises
//  frame_count  out  16  frames started, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. Async assert, sync release.
//  - p_clock toggles every clk. vsync, href and p_data change only on the clk
//    where p_clock falls, so they are stable at each rising edge.
//  - One pixel = 2 bytes = 4 clk. Line length = 2*H_TOTAL bytes; byte counter
//    hcnt runs 0..2*H_TOTAL-1. Line counter vcnt counts within the frame.
//  - FSM states: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT -> (VSYNC | IDLE).
//    IDLE:   leave when enable=1 at a line boundary. Pulse frame_start,
//            increment frame_count, latch mode and solid_rgb.
//    VSYNC:  vsync=1 for VSYNC_LINES full lines.
//    VBACK:  V_BACK lines with href=0.
//    ACTIVE: V_ACTIVE lines. href=1 for hcnt<2*H_ACTIVE, else 0.
//    VFRONT: V_FRONT lines. At the end, go to VSYNC if enable=1, else IDLE.
//  - Deasserting enable mid-frame has no effect until the frame completes.
//    Mode changes mid-frame are ignored.
//  - Pixel (col,row), col 0..H_ACTIVE-1, row 0..V_ACTIVE-1:
//    mode0 colour bars, 8 equal bars of H_ACTIVE/8 px: white, yellow, cyan,
//          green, magenta, red, blue, black (FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000)
//    mode1 ramp: {col[4:0], row[5:0], col[4:0]}
//    mode2 solid_rgb
//    mode3 checker: (col[3]^row[3]^frame_count[0]) ? FFFF : 0000
//  - Even byte = pixel[15:8], odd byte = pixel[7:0]. p_data=0 whenever href=0.
//  - Pixel value is computed one byte early (1-stage pipe), so there are no
//    bubbles at href rise.
//  - hcnt and vcnt wrap to 0 at their totals. Wrap and state change happen on
//    the same p_clock fall.
// STRUCTURE
//  - Shared package dvp_pkg: mode encodings (MODE_BARS, MODE_RAMP, MODE_SOLID,
//    MODE_CHECK), bar colour constants, FSM state typedef.
//  - Sub-module dvp_pattern_gen: combinational col/row/mode/frame -> RGB565.
//  - Top holds p_clock divider, h/v counters, FSM and output registers.
// TESTING (small params: H_ACTIVE=8 H_TOTAL=12 VSYNC_LINES=1 V_BACK=1 V_ACTIVE=4 V_FRONT=1)
//  - Reset, enable=0 -> p_clock toggles, vsync/href/p_data/frame_count stay 0.
//  - enable=1, mode=2, solid_rgb=0x1234 -> frame_start pulse, vsync high for
//    24 bytes, 4 lines of 16 href bytes alternating 12,34, frame_count=1.
//  - mode=0 -> bytes per line FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
//  - Drop enable during ACTIVE line 1 -> frame finishes, then IDLE. Only one frame_start.
//  - Loopback into camera_read, mode=3 -> captured pixels match the model for
//    2 frames, checker inverts.
//  - resetn low mid-line -> all outputs 0 immediately. After release, first vsync
//    comes from IDLE with frame_count=1.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP test-pattern source:
// pattern modes, colour-bar palette and frame FSM states.
package dvp_pkg;

   localparam logic [1:0] MODE_BARS  = 2'd0;
   localparam logic [1:0] MODE_RAMP  = 2'd1;
   localparam logic [1:0] MODE_SOLID = 2'd2;
   localparam logic [1:0] MODE_CHECK = 2'd3;

   localparam logic [15:0] C_WHITE   = 16'hFFFF;
   localparam logic [15:0] C_YELLOW  = 16'hFFE0;
   localparam logic [15:0] C_CYAN    = 16'h07FF;
   localparam logic [15:0] C_GREEN   = 16'h07E0;
   localparam logic [15:0] C_MAGENTA = 16'hF81F;
   localparam logic [15:0] C_RED     = 16'hF800;
   localparam logic [15:0] C_BLUE    = 16'h001F;
   localparam logic [15:0] C_BLACK   = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_VFRONT
   } state_e;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      unique case (idx)
         3'd0:    c = C_WHITE;
         3'd1:    c = C_YELLOW;
         3'd2:    c = C_CYAN;
         3'd3:    c = C_GREEN;
         3'd4:    c = C_MAGENTA;
         3'd5:    c = C_RED;
         3'd6:    c = C_BLUE;
         default: c = C_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 test-pattern generator:
// maps pixel column/row, latched mode and frame parity to a colour.
module dvp_pattern_gen
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE = 640
) (
   input  logic [1:0]  mode_i,
   input  logic [15:0] col_i,
   input  logic [5:0]  row_i,
   input  logic        frame_lsb_i,
   input  logic [15:0] solid_i,
   output logic [15:0] pix_o
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [2:0] bar_idx;

   assign bar_idx = 3'(col_i / 16'(BAR_W));

   // Select the colour for the requested pattern
   always_comb begin
      pix_o = C_BLACK;
      unique case (mode_i)
         MODE_BARS:  pix_o = bar_colour(bar_idx);
         MODE_RAMP:  pix_o = {col_i[4:0], row_i, col_i[4:0]};
         MODE_SOLID: pix_o = solid_i;
         default:    pix_o = (col_i[3] ^ row_i[3] ^ frame_lsb_i) ? C_WHITE : C_BLACK;
      endcase
   end

endmodule

// File: rtl/dvp_camera_source.sv
// OV7670-style DVP transmitter with built-in test patterns.
// Outputs update on the clk where p_clock falls, stable at its rising edge.
module dvp_camera_source
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int H_TOTAL     = 784,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [15:0] solid_rgb,
   output logic        p_clock,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  p_data,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_BYTES     = 2 * H_TOTAL;
   localparam int V_TOTAL     = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int V_ACT_START = VSYNC_LINES + V_BACK;
   localparam int HW          = $clog2(H_BYTES);
   localparam int VW          = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST      = HW'(H_BYTES - 1);
   localparam logic [HW-1:0] H_ACT_BYTES = HW'(2 * H_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_LAST = VW'(VSYNC_LINES - 1);
   localparam logic [VW-1:0] V_BACK_LAST = VW'(V_ACT_START - 1);
   localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_ACT_START + V_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ROW0      = VW'(V_ACT_START);

   logic [1:0]    rst_sync_q;
   logic          rst_n;
   logic          pclk_q;
   logic          tick;
   logic          line_end;
   logic          start;
   state_e        state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic [1:0]    mode_q, mode_d;
   logic [15:0]   solid_q, solid_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic          vsync_q, vsync_d;
   logic          href_q, href_d;
   logic [7:0]    pdata_q, pdata_d;
   logic          fstart_q;
   logic [15:0]   pix;

   // Reset asserts asynchronously and releases two clocks later
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n    = rst_sync_q[1];
   assign tick     = pclk_q;
   assign line_end = (hcnt_q == H_LAST);

   // Free-running byte clock divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pclk_q <= 1'b0;
      else        pclk_q <= ~pclk_q;
   end

   // Frame FSM state and position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         mode_q  <= MODE_BARS;
         solid_q <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         mode_q  <= mode_d;
         solid_q <= solid_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Advance position on p_clock fall; states change only at line wrap
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      start   = 1'b0;
      if (tick) begin
         hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
         if (line_end) begin
            unique case (state_q)
               ST_IDLE: begin
                  vcnt_d = '0;
                  if (enable) begin
                     state_d = ST_VSYNC;
                     start   = 1'b1;
                  end
               end
               ST_VSYNC: begin
                  vcnt_d = vcnt_q + 1'b1;
                  if (vcnt_q == V_SYNC_LAST) state_d = ST_VBACK;
               end
               ST_VBACK: begin
                  vcnt_d = vcnt_q + 1'b1;
                  if (vcnt_q == V_BACK_LAST) state_d = ST_ACTIVE;
               end
               ST_ACTIVE: begin
                  vcnt_d = vcnt_q + 1'b1;
                  if (vcnt_q == V_ACT_LAST) state_d = ST_VFRONT;
               end
               ST_VFRONT: begin
                  vcnt_d = vcnt_q + 1'b1;
                  if (vcnt_q == V_LAST) begin
                     vcnt_d  = '0;
                     state_d = enable ? ST_VSYNC : ST_IDLE;
                     start   = enable;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   // Frame-start bookkeeping: latch pattern settings, count frames
   always_comb begin
      mode_d  = mode_q;
      solid_d = solid_q;
      fcnt_d  = fcnt_q;
      if (start) begin
         mode_d  = mode;
         solid_d = solid_rgb;
         fcnt_d  = fcnt_q + 16'd1;
      end
   end

   dvp_pattern_gen #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pattern (
      .mode_i      (mode_q),
      .col_i       (16'(hcnt_d >> 1)),
      .row_i       (6'(vcnt_d - V_ROW0)),
      .frame_lsb_i (fcnt_q[0]),
      .solid_i     (solid_q),
      .pix_o       (pix)
   );

   // Output values for the byte slot being entered
   always_comb begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE) && (hcnt_d < H_ACT_BYTES);
      pdata_d = 8'h00;
      if (href_d) pdata_d = hcnt_d[0] ? pix[7:0] : pix[15:8];
   end

   // Output registers, loaded only when p_clock falls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q  <= 1'b0;
         href_q   <= 1'b0;
         pdata_q  <= 8'h00;
         fstart_q <= 1'b0;
      end else begin
         fstart_q <= start;
         if (tick) begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            pdata_q <= pdata_d;
         end
      end
   end

   assign p_clock     = pclk_q;
   assign vsync       = vsync_q;
   assign href        = href_q;
   assign p_data      = pdata_q;
   assign frame_start = fstart_q;
   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_dvp_camera_source.sv
// Randomized self-checking bench for dvp_camera_source:
// parses the byte stream per frame against a pixel reference model.
module tb_dvp_camera_source;

   localparam int H_ACT = 8;
   localparam int H_TOT = 12;
   localparam int VS_L  = 1;
   localparam int VB_L  = 1;
   localparam int VA_L  = 4;
   localparam int VF_L  = 1;
   localparam int LB    = 2 * H_TOT;

   localparam logic [15:0] BARS [8] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] solid_rgb = 16'h0000;
   logic        p_clock;
   logic        vsync;
   logic        href;
   logic [7:0]  p_data;
   logic        frame_start;
   logic [15:0] frame_count;

   int n_chk = 0;
   int n_fail = 0;
   int fs_cnt = 0;
   int fs_base = 0;

   logic       s_vs = 1'b0;
   logic       s_hr = 1'b0;
   logic [7:0] s_pd = 8'h00;

   dvp_camera_source #(
      .H_ACTIVE    (H_ACT),
      .H_TOTAL     (H_TOT),
      .VSYNC_LINES (VS_L),
      .V_BACK      (VB_L),
      .V_ACTIVE    (VA_L),
      .V_FRONT     (VF_L)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .mode        (mode),
      .solid_rgb   (solid_rgb),
      .p_clock     (p_clock),
      .vsync       (vsync),
      .href        (href),
      .p_data      (p_data),
      .frame_start (frame_start),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && frame_start) begin
         fs_cnt++;
         chk("fs_vsync", 32'(vsync), 32'd1);
      end
   end

   function automatic logic [15:0] model_px(input logic [1:0] md, input logic [15:0] sc,
                                            input logic [15:0] fc, input int col, input int row);
      logic [15:0] c;
      logic [15:0] r;
      c = 16'(col);
      r = 16'(row);
      case (md)
         2'd0:    return BARS[col / (H_ACT / 8)];
         2'd1:    return {c[4:0], r[5:0], c[4:0]};
         2'd2:    return sc;
         default: return (c[3] ^ r[3] ^ fc[0]) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   task automatic get_byte();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!p_clock && k < 8);
      if (!p_clock) chk("pclk_run", 32'(p_clock), 32'd1);
      s_vs = vsync;
      s_hr = href;
      s_pd = p_data;
   endtask

   task automatic check_frame(input logic [1:0] md, input logic [15:0] sc, input logic [15:0] fc,
                              input logic [1:0] nmd, input logic [15:0] nsc, input logic nen);
      int n;
      int bad;
      logic [15:0] px;
      logic [7:0] eb;
      n = 0;
      bad = 0;
      while (!s_vs && n < 400) begin
         get_byte();
         n++;
      end
      chk("vs_found", 32'(s_vs), 32'd1);
      chk("fcount", 32'(frame_count), 32'(fc));
      chk("fs_cnt", 32'(fs_cnt - fs_base), 32'(fc));
      n = 1;
      get_byte();
      while (s_vs && n < 200) begin
         if (s_hr || s_pd != 8'h00) bad++;
         n++;
         get_byte();
      end
      chk("vs_len", 32'(n), 32'(VS_L * LB));
      n = 0;
      while (!s_hr && n < 400) begin
         if (s_vs || s_pd != 8'h00) bad++;
         n++;
         get_byte();
      end
      chk("vback_len", 32'(n), 32'(VB_L * LB));
      for (int r = 0; r < VA_L; r++) begin
         if (r > 0) begin
            n = 0;
            while (!s_hr && n < 400) begin
               if (s_vs || s_pd != 8'h00) bad++;
               n++;
               get_byte();
            end
            chk("hblank_len", 32'(n), 32'(LB - 2 * H_ACT));
         end
         for (int b = 0; b < 2 * H_ACT; b++) begin
            if (b > 0) get_byte();
            px = model_px(md, sc, fc, b / 2, r);
            eb = (b % 2 == 1) ? px[7:0] : px[15:8];
            chk("href", 32'(s_hr), 32'd1);
            chk("pdata", 32'(s_pd), 32'(eb));
            if (r == 1 && b == 0) begin
               mode = nmd;
               solid_rgb = nsc;
               enable = nen;
            end
         end
         get_byte();
      end
      for (int k = 0; k < LB - 2 * H_ACT + VF_L * LB; k++) begin
         if (s_hr || s_vs || s_pd != 8'h00) bad++;
         get_byte();
      end
      chk("blank_clean", 32'(bad), 32'd0);
      chk("next_vs", 32'(s_vs), 32'(nen));
   endtask

   initial begin
      int bad;
      int tog;
      int n;
      int exp_fc;
      logic pc_prev;
      logic [1:0] cur_md;
      logic [1:0] nxt_md;
      logic [15:0] cur_sc;
      logic [15:0] nxt_sc;
      logic [15:0] sc;

      repeat (3) @(negedge clk);
      chk("rst_out", 32'({p_clock, vsync, href, p_data, frame_start, frame_count}), 32'd0);
      resetn = 1'b1;

      bad = 0;
      tog = 0;
      pc_prev = p_clock;
      repeat (100) begin
         @(negedge clk);
         if (p_clock != pc_prev) tog++;
         pc_prev = p_clock;
         if (vsync || href || frame_start || p_data != 8'h00 || frame_count != 16'h0) bad++;
      end
      chk("idle_toggle", 32'(tog > 90), 32'd1);
      chk("idle_quiet", 32'(bad), 32'd0);

      cur_md = 2'd2;
      cur_sc = 16'h1234;
      mode = cur_md;
      solid_rgb = cur_sc;
      enable = 1'b1;
      fs_base = fs_cnt;
      exp_fc = 0;
      get_byte();
      for (int f = 0; f < 8; f++) begin
         case (f)
            0:       nxt_md = 2'd0;
            1:       nxt_md = 2'd1;
            2:       nxt_md = 2'd3;
            3:       nxt_md = 2'd3;
            default: nxt_md = 2'($urandom_range(0, 3));
         endcase
         nxt_sc = 16'($urandom);
         exp_fc++;
         check_frame(cur_md, cur_sc, 16'(exp_fc), nxt_md, nxt_sc, f != 7);
         cur_md = nxt_md;
         cur_sc = nxt_sc;
      end

      bad = 0;
      repeat (60) begin
         get_byte();
         if (s_vs || s_hr) bad++;
      end
      chk("idle_after", 32'(bad), 32'd0);
      chk("fs_total", 32'(fs_cnt - fs_base), 32'(exp_fc));
      chk("fc_hold", 32'(frame_count), 32'(exp_fc));

      enable = 1'b1;
      n = 0;
      while (!s_hr && n < 1000) begin
         get_byte();
         n++;
      end
      chk("href_seen", 32'(s_hr), 32'd1);
      repeat (3) get_byte();
      #3 resetn = 1'b0;
      #1 chk("rst_async", 32'({p_clock, vsync, href, p_data, frame_start, frame_count}), 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_hold", 32'({p_clock, vsync, href, p_data, frame_start, frame_count}), 32'd0);
      sc = 16'($urandom);
      mode = 2'd2;
      solid_rgb = sc;
      fs_base = fs_cnt;
      s_vs = 1'b0;
      resetn = 1'b1;
      get_byte();
      check_frame(2'd2, sc, 16'd1, 2'd2, sc, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
